sobel_window_ctrl: RTL and testbench



---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sobel_window_ctrl_ram.sv | 41 ++++
 rtl/sobel_window_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window front-end.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PIC_WIDTH  = 250;
  localparam int DEF_PIC_HEIGHT = 250;
  localparam int COL_W          = $clog2(DEF_PIC_WIDTH);
  localparam int ROW_W          = $clog2(DEF_PIC_HEIGHT);

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_window_ctrl_ram.sv
// Single-port line RAM: read-before-write with a registered read word.
// old_o exposes the pre-write word so a second RAM can be cascaded in the same cycle.
module sobel_line_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_PIC_WIDTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] old_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  assign old_o   = mem_q[addr_i];
  assign rdata_o = rdata_q;

  // Storage array write.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read of the word being replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel front-end: buffers two rows and presents three vertically aligned taps
// with a one-cycle latency, gating the first two rows of every frame.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [WIDTH-1:0] pix_data,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             busy,
  output logic             frame_done,
  output logic             err_drop
);

  localparam int CW = cnt_w(PIC_WIDTH);
  localparam int RW = cnt_w(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_e           state_q, state_d, eff_state_s;
  logic [CW-1:0]    col_q, col_d, eff_col_s;
  logic [RW-1:0]    row_q, row_d, eff_row_s;
  logic             accept_s;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] dout3_q;
  logic [WIDTH-1:0] ram_a_old_s;
  logic [WIDTH-1:0] ram_b_old_unused;

  // frame_start overrides the current position so a coincident pixel lands at row 0, col 0.
  always_comb begin
    eff_state_s = state_q;
    eff_col_s   = col_q;
    eff_row_s   = row_q;
    if (frame_start) begin
      eff_state_s = ST_FILL;
      eff_col_s   = '0;
      eff_row_s   = '0;
    end else begin
      eff_state_s = state_q;
    end
    accept_s = pix_valid && ((eff_state_s == ST_FILL) || (eff_state_s == ST_RUN));
  end

  // Next-state, raster counters and output strobes.
  always_comb begin
    state_d = eff_state_s;
    col_d   = eff_col_s;
    row_d   = eff_row_s;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (eff_state_s)
      ST_IDLE: begin
        err_d = pix_valid;
      end
      ST_DONE: begin
        err_d   = pix_valid;
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
      ST_FILL, ST_RUN: begin
        if (pix_valid) begin
          valid_d = (eff_state_s == ST_RUN);
          if (eff_col_s == COL_LAST) begin
            col_d = '0;
            row_d = eff_row_s + RW'(1);
            if ((eff_state_s == ST_FILL) && (eff_row_s == ROW_ONE)) begin
              state_d = ST_RUN;
            end else if ((eff_state_s == ST_RUN) && (eff_row_s == ROW_LAST)) begin
              state_d = ST_DONE;
              row_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = eff_state_s;
            end
          end else begin
            col_d = eff_col_s + CW'(1);
          end
        end else begin
          col_d = eff_col_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_FILL) || (state_d == ST_RUN);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Bottom tap holds across gaps like the RAM read words do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout3_q <= '0;
    end else if (accept_s) begin
      dout3_q <= pix_data;
    end
  end

  // RAM_A holds row r-1 and feeds its displaced word into RAM_B (row r-2).
  sobel_line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH), .AW(CW)) u_ram_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept_s),
    .addr_i (eff_col_s),
    .wdata_i(pix_data),
    .rdata_o(dout2),
    .old_o  (ram_a_old_s)
  );

  sobel_line_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH), .AW(CW)) u_ram_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept_s),
    .addr_i (eff_col_s),
    .wdata_i(ram_a_old_s),
    .rdata_o(dout1),
    .old_o  (ram_b_old_unused)
  );

  assign valid_out  = valid_q;
  assign dout3      = dout3_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err_drop   = err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 4x4 frame against a raster-index model.
module tb_sobel_window_ctrl;

  localparam int PW = 4;
  localparam int PH = 4;
  localparam int NPIX = PW * PH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic       valid_out, busy, frame_done, err_drop;
  logic [7:0] dout1, dout2, dout3;

  int errors = 0;
  int checks = 0;

  // reference model: frame pixels indexed by raster position
  logic [7:0] img [NPIX];
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic       exp_valid, exp_done, exp_err, exp_busy;
  logic [7:0] exp_d1, exp_d2, exp_d3;

  sobel_window_ctrl #(.PIC_WIDTH(PW), .PIC_HEIGHT(PH), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .valid_out(valid_out), .dout1(dout1), .dout2(dout2),
    .dout3(dout3), .busy(busy), .frame_done(frame_done), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 1'b0; m_k = 0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
    exp_d1 = 8'd0; exp_d2 = 8'd0; exp_d3 = 8'd0;
  endtask

  // drive one cycle and predict what the outputs show one cycle later
  task automatic drive_cycle(input bit fs, input bit pv, input logic [7:0] d);
    frame_start = fs; pix_valid = pv; pix_data = d;
    exp_valid = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    if (fs) begin m_active = 1'b1; m_k = 0; end
    if (pv && m_active) begin
      img[m_k] = d;
      if (m_k >= 2 * PW) begin
        exp_valid = 1'b1;
        exp_d1 = img[m_k - 2 * PW]; exp_d2 = img[m_k - PW]; exp_d3 = d;
      end
      if (m_k == NPIX - 1) begin exp_done = 1'b1; m_active = 1'b0; end
      m_k++;
    end else if (pv) begin
      exp_err = 1'b1;
    end
    exp_busy = m_active;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid_out, busy, frame_done, err_drop, dout1, dout2, dout3} !== 28'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {valid_out, busy, frame_done, err_drop, dout1, dout2, dout3});
    end
    checks++;
    if ({u_dut.col_q, u_dut.row_q} !== 4'd0) begin
      errors++; $display("FAIL reset_counters got %h want 0", {u_dut.col_q, u_dut.row_q});
    end
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_err_idle();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 8'($urandom));
      checks++;
      if (err_drop !== 1'b1 || valid_out !== 1'b0) begin
        errors++; $display("FAIL idle_err got err=%b valid=%b want err=1 valid=0", err_drop, valid_out);
      end
    end
    drive_cycle(1'b0, 1'b0, 8'd0);
    checks++;
    if (err_drop !== 1'b0 || {u_dut.col_q, u_dut.row_q} !== 4'd0) begin
      errors++; $display("FAIL idle_hold got err=%b colrow=%h want 0 0", err_drop, {u_dut.col_q, u_dut.row_q});
    end
  endtask

  task automatic test_full_frame();
    int nvalid = 0;
    drive_cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < NPIX + 2; i++) begin
      if (i < NPIX) drive_cycle(1'b0, 1'b1, 8'(i));
      else drive_cycle(1'b0, 1'b0, 8'd0);
      if (valid_out === 1'b1) nvalid++;
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_done || busy !== exp_busy) begin
        errors++; $display("FAIL frame_ctrl px=%0d got v=%b d=%b b=%b want v=%b d=%b b=%b",
                           i, valid_out, frame_done, busy, exp_valid, exp_done, exp_busy);
      end
      if (exp_valid) begin
        checks++;
        if ({dout1, dout2, dout3} !== {exp_d1, exp_d2, exp_d3}) begin
          errors++; $display("FAIL frame_taps px=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                             i, dout1, dout2, dout3, exp_d1, exp_d2, exp_d3);
        end
      end
      if (i == 8 || i == 15) begin
        checks++;
        if ({dout1, dout2, dout3} !== ((i == 8) ? {8'd0, 8'd4, 8'd8} : {8'd7, 8'd11, 8'd15})) begin
          errors++; $display("FAIL frame_edge_triplet px=%0d got %0d,%0d,%0d", i, dout1, dout2, dout3);
        end
      end
    end
    checks++;
    if (nvalid !== (PH - 2) * PW) begin
      errors++; $display("FAIL frame_valid_count got %0d want %0d", nvalid, (PH - 2) * PW);
    end
  endtask

  task automatic test_gap();
    int nvalid = 0;
    drive_cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < NPIX; i++) begin
      drive_cycle(1'b0, 1'b1, 8'(i));
      if (valid_out === 1'b1) nvalid++;
      if (i == 9) begin
        for (int g = 0; g < 3; g++) begin
          drive_cycle(1'b0, 1'b0, 8'd0);
          checks++;
          if (valid_out !== 1'b0 || dout3 !== 8'd9 || u_dut.col_q !== 2'd2 || u_dut.row_q !== 2'd2) begin
            errors++; $display("FAIL gap_hold got v=%b d3=%0d col=%0d row=%0d want 0 9 2 2",
                               valid_out, dout3, u_dut.col_q, u_dut.row_q);
          end
        end
      end
      if (i == 10) begin
        checks++;
        if ({valid_out, dout1, dout2, dout3} !== {1'b1, 8'd2, 8'd6, 8'd10}) begin
          errors++; $display("FAIL gap_resume got v=%b %0d,%0d,%0d want 1 2,6,10", valid_out, dout1, dout2, dout3);
        end
      end
    end
    checks++;
    if (nvalid !== 8) begin
      errors++; $display("FAIL gap_valid_count got %0d want 8", nvalid);
    end
    drive_cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_abort();
    drive_cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b1, 8'($urandom));
    drive_cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < NPIX; i++) begin
      drive_cycle(1'b0, 1'b1, 8'(100 + i));
      checks++;
      if (valid_out !== exp_valid) begin
        errors++; $display("FAIL abort_valid px=%0d got %b want %b", i, valid_out, exp_valid);
      end
      if (i == 8) begin
        checks++;
        if ({dout1, dout2, dout3} !== {8'd100, 8'd104, 8'd108}) begin
          errors++; $display("FAIL abort_first got %0d,%0d,%0d want 100,104,108", dout1, dout2, dout3);
        end
      end
    end
    drive_cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 1'b0, 8'd0);
    for (int i = 0; i <= 10; i++) drive_cycle(1'b0, 1'b1, 8'(i));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({valid_out, busy, frame_done, err_drop, dout1, dout2, dout3} !== 28'd0) begin
      errors++; $display("FAIL reset_mid_async got %h want 0", {valid_out, busy, frame_done, err_drop, dout1, dout2, dout3});
    end
    frame_start = 1'b0; pix_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 8'($urandom));
      checks++;
      if (err_drop !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_mid_drop got e=%b v=%b b=%b want 1 0 0", err_drop, valid_out, busy);
      end
    end
    drive_cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_start_with_pixel();
    drive_cycle(1'b1, 1'b1, 8'd50);
    checks++;
    if (err_drop !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_pix_accept got e=%b b=%b want 0 1", err_drop, busy);
    end
    for (int i = 1; i <= 8; i++) drive_cycle(1'b0, 1'b1, 8'($urandom_range(0, 40)));
    checks++;
    if (valid_out !== 1'b1 || dout1 !== 8'd50 || dout3 !== exp_d3) begin
      errors++; $display("FAIL start_pix_first got v=%b d1=%0d d3=%0d want 1 50 %0d", valid_out, dout1, dout3, exp_d3);
    end
    for (int i = 9; i < NPIX + 1; i++) drive_cycle(1'b0, 1'b0 ^ (i < NPIX), 8'($urandom));
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int sent = 0;
      int nvalid = 0;
      drive_cycle(1'b1, 1'b0, 8'd0);
      for (int c = 0; c < 200 && sent < NPIX + 2; c++) begin
        bit pv = ($urandom_range(0, 3) != 0);
        if (pv) sent++;
        drive_cycle(1'b0, pv, 8'($urandom));
        if (valid_out === 1'b1) nvalid++;
        checks++;
        if ({valid_out, frame_done, err_drop, busy} !== {exp_valid, exp_done, exp_err, exp_busy}) begin
          errors++; $display("FAIL rand_ctrl f=%0d c=%0d got %b want %b", f, c,
                             {valid_out, frame_done, err_drop, busy}, {exp_valid, exp_done, exp_err, exp_busy});
        end
        if (exp_valid && {dout1, dout2, dout3} !== {exp_d1, exp_d2, exp_d3}) begin
          errors++; $display("FAIL rand_taps f=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                             f, dout1, dout2, dout3, exp_d1, exp_d2, exp_d3);
        end
      end
      checks++;
      if (nvalid !== (PH - 2) * PW) begin
        errors++; $display("FAIL rand_valid_count f=%0d got %0d want %0d", f, nvalid, (PH - 2) * PW);
      end
    end
  endtask

  initial begin
    test_reset();
    test_err_idle();
    test_full_frame();
    test_gap();
    test_abort();
    test_reset_mid();
    test_start_with_pixel();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
